// File: rtl/amds_sched_pkg.sv
// amds_sched_pkg
// Shared definitions for the AMDS trigger scheduler:
//   state_t    - scheduler FSM states (IDLE/TRIG/WAIT/DONE)
//   DEF_*      - default parameter values for the scheduler and its counters
//   sat_inc    - saturating increment for counters up to SAT_MAX_W bits wide
package amds_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRIG = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_N_CH      = 2;
  localparam int DEF_TRIG_LEN  = 4;
  localparam int DEF_TIMEOUT_W = 16;
  localparam int DEF_CNT_W     = 16;

  // Widest counter sat_inc can handle; callers zero-extend into this width
  // and truncate the result back to their own width.
  localparam int SAT_MAX_W = 32;

  // Returns value+1, or holds at the all-ones value of a 'width'-bit counter.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] value,
                                                   input int unsigned width);
    logic [SAT_MAX_W-1:0] max_val;
    if (width >= SAT_MAX_W) max_val = '1;
    else max_val = (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
    if (value >= max_val) return max_val;
    else return value + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/amds_sat_counter.sv
// amds_sat_counter
// Saturating event counter used for the scheduler's diagnostic counters.
// Ports:
//   clk   - clock
//   rst   - asynchronous active-high reset, clears count
//   inc   - count one event this cycle
//   count - current count, holds at 2^CNT_W-1
module amds_sat_counter
  import amds_sched_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else if (inc) count <= CNT_W'(sat_inc(SAT_MAX_W'(count), CNT_W));
  end

endmodule

// File: rtl/amds_trigger_scheduler.sv
// amds_trigger_scheduler
// Turns PWM carrier peak/valley events into fixed-width sync_adc pulses for
// the AMDS board, then waits for every serial receiver to report a frame or
// for the programmable timeout to expire.
// Ports:
//   ACLK, ARESET    - clock, asynchronous active-high reset
//   enable          - scheduler enable; dropping it aborts a sequence
//   trig_on_high/low- select carrier peak and/or valley as trigger source
//   carrier_high/low- single-cycle carrier peak/valley pulses
//   timeout_cycles  - WAIT limit in cycles, 0 = wait forever
//   ch_done         - per-channel single-cycle frame-received pulses
//   sync_adc        - trigger pulse to the AMDS board (TRIG_LEN cycles)
//   busy            - scheduler not idle
//   data_valid      - channels that delivered data in the last sequence
//   irq             - single-cycle end-of-sequence pulse
//   timeout_cnt     - saturating count of sequences ended by timeout
//   missed_cnt      - saturating count of triggers dropped while busy
module amds_trigger_scheduler
  import amds_sched_pkg::*;
#(
  parameter int N_CH      = DEF_N_CH,
  parameter int TRIG_LEN  = DEF_TRIG_LEN,
  parameter int TIMEOUT_W = DEF_TIMEOUT_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 enable,
  input  logic                 trig_on_high,
  input  logic                 trig_on_low,
  input  logic                 carrier_high,
  input  logic                 carrier_low,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic [N_CH-1:0]      ch_done,
  output logic                 sync_adc,
  output logic                 busy,
  output logic [N_CH-1:0]      data_valid,
  output logic                 irq,
  output logic [CNT_W-1:0]     timeout_cnt,
  output logic [CNT_W-1:0]     missed_cnt
);

  localparam int TRIG_W = (TRIG_LEN > 1) ? $clog2(TRIG_LEN) : 1;
  localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_LEN - 1);

  state_t               state, state_nxt;
  logic [TRIG_W-1:0]    trig_cnt, trig_cnt_nxt;
  logic [TIMEOUT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [N_CH-1:0]      got, got_nxt;
  logic                 tmo_flag, tmo_flag_nxt;
  logic                 trig_event;
  logic                 missed_inc;
  logic                 timeout_inc;

  // Peak and valley in the same cycle collapse into a single event.
  assign trig_event  = (carrier_high & trig_on_high) | (carrier_low & trig_on_low);
  assign missed_inc  = trig_event & enable & (state != IDLE);
  assign timeout_inc = (state == DONE) & tmo_flag;

  // Next-state logic. got_nxt already includes this cycle's ch_done so that a
  // frame arriving on the final WAIT cycle (including timeout expiry) counts.
  always_comb begin
    state_nxt    = state;
    trig_cnt_nxt = trig_cnt;
    wait_cnt_nxt = wait_cnt;
    got_nxt      = got;
    tmo_flag_nxt = tmo_flag;
    unique case (state)
      IDLE: begin
        if (enable && trig_event) begin
          got_nxt      = '0;
          tmo_flag_nxt = 1'b0;
          trig_cnt_nxt = '0;
          state_nxt    = TRIG;
        end
      end
      TRIG: begin
        got_nxt = got | ch_done;
        if (!enable) begin
          state_nxt = IDLE;
        end else if (trig_cnt == TRIG_LAST) begin
          wait_cnt_nxt = '0;
          state_nxt    = WAIT;
        end else begin
          trig_cnt_nxt = trig_cnt + 1'b1;
        end
      end
      WAIT: begin
        got_nxt = got | ch_done;
        if (!enable) begin
          state_nxt = IDLE;
        end else if (&got_nxt) begin
          state_nxt = DONE;
        end else if ((timeout_cycles != '0) && (wait_cnt == timeout_cycles - 1'b1)) begin
          tmo_flag_nxt = 1'b1;
          state_nxt    = DONE;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state    <= IDLE;
      trig_cnt <= '0;
      wait_cnt <= '0;
      got      <= '0;
      tmo_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      trig_cnt <= trig_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      got      <= got_nxt;
      tmo_flag <= tmo_flag_nxt;
    end
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with the state register and have no combinational path from the inputs.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      sync_adc   <= 1'b0;
      busy       <= 1'b0;
      irq        <= 1'b0;
      data_valid <= '0;
    end else begin
      sync_adc <= (state_nxt == TRIG);
      busy     <= (state_nxt != IDLE);
      irq      <= (state_nxt == DONE);
      if (state_nxt == DONE) data_valid <= got_nxt;
    end
  end

  amds_sat_counter #(.CNT_W(CNT_W)) u_timeout_cnt (
    .clk  (ACLK),
    .rst  (ARESET),
    .inc  (timeout_inc),
    .count(timeout_cnt)
  );

  amds_sat_counter #(.CNT_W(CNT_W)) u_missed_cnt (
    .clk  (ACLK),
    .rst  (ARESET),
    .inc  (missed_inc),
    .count(missed_cnt)
  );

endmodule

// File: tb/tb_amds_trigger_scheduler.sv
// tb_amds_trigger_scheduler
// Self-checking bench for amds_trigger_scheduler: a vector table of complete
// sequences plus hand-written collision, abort, saturation and reset cases.
// Expected irq cycle and data_valid are queued when a sequence is launched
// and compared by a monitor when irq appears.
module tb_amds_trigger_scheduler;

  localparam int N_CH      = 2;
  localparam int TRIG_LEN  = 4;
  localparam int TIMEOUT_W = 16;
  localparam int CNT_W     = 16;
  localparam int CNT_MAX   = 65535;

  logic                 ACLK = 1'b0;
  logic                 ARESET = 1'b0;
  logic                 enable = 1'b0;
  logic                 trig_on_high = 1'b0;
  logic                 trig_on_low = 1'b0;
  logic                 carrier_high = 1'b0;
  logic                 carrier_low = 1'b0;
  logic [TIMEOUT_W-1:0] timeout_cycles = 16'd100;
  logic [N_CH-1:0]      ch_done = '0;
  logic                 sync_adc;
  logic                 busy;
  logic [N_CH-1:0]      data_valid;
  logic                 irq;
  logic [CNT_W-1:0]     timeout_cnt;
  logic [CNT_W-1:0]     missed_cnt;

  typedef struct {
    int         cyc;
    logic [1:0] dv;
  } exp_t;

  typedef struct {
    logic        use_high;
    logic [15:0] tmo;
    int          d0;
    int          d1;
    logic [1:0]  exp_dv;
    int          irq_off;
    int          tmo_inc;
  } vec_t;

  exp_t       sb_q[$];
  vec_t       vecs[8];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         sync_count = 0;
  int         sync_first = 0;
  int         model_tmo = 0;
  int         model_missed = 0;
  logic [1:0] model_dv = 2'b00;

  amds_trigger_scheduler #(
    .N_CH(N_CH), .TRIG_LEN(TRIG_LEN), .TIMEOUT_W(TIMEOUT_W), .CNT_W(CNT_W)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .enable(enable),
    .trig_on_high(trig_on_high), .trig_on_low(trig_on_low),
    .carrier_high(carrier_high), .carrier_low(carrier_low),
    .timeout_cycles(timeout_cycles), .ch_done(ch_done),
    .sync_adc(sync_adc), .busy(busy), .data_valid(data_valid), .irq(irq),
    .timeout_cnt(timeout_cnt), .missed_cnt(missed_cnt)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0d, required %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: measures the sync_adc pulse and checks every irq against the
  // scoreboard; an irq with nothing queued is a failure on its own.
  always @(negedge ACLK) begin
    exp_t e;
    if (sync_adc) begin
      if (sync_count == 0) sync_first = cyc;
      sync_count++;
    end
    if (irq) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL irq_spurious: actual 1, required 0 (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        checkOutput("irq_cycle", cyc, e.cyc);
        checkOutput("data_valid", 32'(data_valid), 32'(e.dv));
      end
    end
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic applyStimulus(input logic ch, input logic cl, input logic [1:0] cd);
    carrier_high = ch;
    carrier_low  = cl;
    ch_done      = cd;
    step();
  endtask

  task automatic runVector(input vec_t v, input int idx);
    int         t;
    logic       done_seen;
    logic [1:0] cd;
    $display("[TB] vector %0d", idx);
    timeout_cycles = v.tmo;
    sync_count = 0;
    t = cyc;
    sb_q.push_back('{t + v.irq_off, v.exp_dv});
    done_seen = 1'b0;
    for (int off = 0; off <= v.irq_off + 20; off++) begin
      cd[0] = (v.d0 == off);
      cd[1] = (v.d1 == off);
      applyStimulus(v.use_high && (off == 0), !v.use_high && (off == 0), cd);
      if (sb_q.size() == 0) begin
        done_seen = 1'b1;
        break;
      end
    end
    carrier_high = 1'b0;
    carrier_low  = 1'b0;
    ch_done      = '0;
    checkOutput("seq_complete", 32'(done_seen), 32'd1);
    sb_q.delete();
    model_tmo += v.tmo_inc;
    model_dv = v.exp_dv;
    checkOutput("timeout_cnt", 32'(timeout_cnt), 32'(model_tmo));
    checkOutput("missed_cnt", 32'(missed_cnt), 32'(model_missed));
    checkOutput("busy_after_done", 32'(busy), 32'd0);
    checkOutput("sync_len", sync_count, TRIG_LEN);
    checkOutput("sync_start", sync_first, t + 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual timeout, required end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    vecs[0] = '{1'b1, 16'd100, 10, 15, 2'b11, 16, 0};
    vecs[1] = '{1'b1, 16'd100, 10, -1, 2'b01, 105, 1};
    vecs[2] = '{1'b0, 16'd100, 8, 8, 2'b11, 9, 0};
    vecs[3] = '{1'b1, 16'd20, -1, 24, 2'b10, 25, 1};
    vecs[4] = '{1'b0, 16'd20, 24, 2, 2'b11, 25, 0};
    vecs[5] = '{1'b1, 16'd1, -1, -1, 2'b00, 6, 1};
    vecs[6] = '{1'b1, 16'd100, 2, 3, 2'b11, 6, 0};
    vecs[7] = '{1'b1, 16'd3, 0, 0, 2'b00, 8, 1};

    // Reset
    #1 ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK) ARESET = 1'b0;
    step();
    checkOutput("rst_sync_adc", 32'(sync_adc), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_irq", 32'(irq), 0);
    checkOutput("rst_data_valid", 32'(data_valid), 0);
    checkOutput("rst_timeout_cnt", 32'(timeout_cnt), 0);
    checkOutput("rst_missed_cnt", 32'(missed_cnt), 0);

    // Trigger gating: disabled source and disabled scheduler both ignore events
    enable = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'b00);
    checkOutput("no_src_busy", 32'(busy), 0);
    trig_on_high = 1'b1;
    trig_on_low  = 1'b1;
    enable = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'b00);
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("disabled_busy", 32'(busy), 0);
    checkOutput("disabled_missed", 32'(missed_cnt), 0);
    enable = 1'b1;

    foreach (vecs[i]) runVector(vecs[i], i);

    // Collision: valley while busy, peak+valley together, peak in DONE cycle
    $display("[TB] collision");
    timeout_cycles = 16'd100;
    sync_count = 0;
    t = cyc;
    sb_q.push_back('{t + 32, 2'b11});
    for (int off = 0; off <= 35; off++) begin
      applyStimulus((off == 0) || (off == 21) || (off == 32),
                    (off == 20) || (off == 21),
                    (off == 30) ? 2'b01 : ((off == 31) ? 2'b10 : 2'b00));
    end
    model_missed += 3;
    model_dv = 2'b11;
    checkOutput("coll_irq_seen", sb_q.size(), 0);
    sb_q.delete();
    checkOutput("coll_missed", 32'(missed_cnt), 32'(model_missed));
    checkOutput("coll_sync_len", sync_count, TRIG_LEN);
    checkOutput("coll_busy", 32'(busy), 0);

    // Abort inside TRIG
    $display("[TB] abort");
    t = cyc;
    applyStimulus(1'b1, 1'b0, 2'b00);
    applyStimulus(1'b0, 1'b0, 2'b00);
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("abort_sync_before", 32'(sync_adc), 1);
    enable = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("abort_sync_adc", 32'(sync_adc), 0);
    checkOutput("abort_busy", 32'(busy), 0);
    enable = 1'b1;
    // Abort inside WAIT, then idle long enough for any stray timeout irq
    applyStimulus(1'b1, 1'b0, 2'b00);
    repeat (9) applyStimulus(1'b0, 1'b0, 2'b01);
    enable = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("abort_wait_busy", 32'(busy), 0);
    enable = 1'b1;
    repeat (110) applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("abort_data_valid", 32'(data_valid), 32'(model_dv));
    checkOutput("abort_timeout_cnt", 32'(timeout_cnt), 32'(model_tmo));
    checkOutput("abort_missed_cnt", 32'(missed_cnt), 32'(model_missed));

    // Disabled timeout with a continuous trigger stream driving missed_cnt to saturation
    $display("[TB] saturation");
    timeout_cycles = '0;
    applyStimulus(1'b1, 1'b0, 2'b00);
    for (int i = 0; model_missed < CNT_MAX; i++) begin
      applyStimulus(1'b1, 1'b0, 2'b00);
      model_missed++;
      if (i == 5000) begin
        checkOutput("no_timeout_busy", 32'(busy), 1);
        checkOutput("missed_progress", 32'(missed_cnt), 32'(model_missed));
      end
    end
    checkOutput("missed_at_max", 32'(missed_cnt), CNT_MAX);
    applyStimulus(1'b1, 1'b0, 2'b00);
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("missed_saturated", 32'(missed_cnt), CNT_MAX);
    checkOutput("long_wait_busy", 32'(busy), 1);
    sb_q.push_back('{cyc + 1, 2'b11});
    applyStimulus(1'b0, 1'b0, 2'b11);
    applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("long_wait_irq_seen", sb_q.size(), 0);
    sb_q.delete();
    checkOutput("long_wait_busy_end", 32'(busy), 0);
    checkOutput("long_wait_timeout_cnt", 32'(timeout_cnt), 32'(model_tmo));

    // Asynchronous reset in the middle of WAIT
    $display("[TB] async reset");
    timeout_cycles = 16'd100;
    applyStimulus(1'b1, 1'b0, 2'b00);
    repeat (7) applyStimulus(1'b0, 1'b0, 2'b00);
    checkOutput("pre_reset_busy", 32'(busy), 1);
    #2 ARESET = 1'b1;
    #1;
    checkOutput("arst_sync_adc", 32'(sync_adc), 0);
    checkOutput("arst_busy", 32'(busy), 0);
    checkOutput("arst_irq", 32'(irq), 0);
    checkOutput("arst_data_valid", 32'(data_valid), 0);
    checkOutput("arst_timeout_cnt", 32'(timeout_cnt), 0);
    checkOutput("arst_missed_cnt", 32'(missed_cnt), 0);
    @(negedge ACLK) ARESET = 1'b0;
    step();
    model_tmo = 0;
    model_missed = 0;
    runVector(vecs[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
